correction_ms: RTL and testbench
================================

// Module: correction_ms
// PURPOSE
//  Multi-lane, multi-stage final correction for Montgomery/modular multiplier outputs. Reduces C in [0, 2^NSUB*q)
//  to T = C mod q with NSUB conditional subtractions of q<<k, k = NSUB-1..0, where q = {qH, {R-1{0}}, 1}, R = LOGQ-LOGQH.
//  Adds a valid pipeline, a runtime-loadable modulus with safe-load handshake, and an overflow flag.
//  Sits after the reduction datapath and feeds the multiplier output port.
// PARAMETERS
//  LOGQ    64   modulus/result width (bits)
//  LOGQH   17   width of the loadable modulus high part qH; R = LOGQ-LOGQH >= 0 (R=0 -> q = qH)
//  NSUB    2    number of conditional-subtract stages; input range [0, 2^NSUB*q)
//  LANES   1    independent parallel lanes sharing one q
//  TAGW    4    sideband tag width, carried alongside valid
//  FF_IN   1    register inputs (data, valid, tag)
//  FF_STG  '1   NSUB-bit mask; bit k=1 registers the output of stage k
//  FF_OUT  1    register outputs
// PORTS
//  clk       in   1               clock
//  rst       in   1               synchronous, active-high reset
//  q_ld      in   1               request to load new qH
//  q_ld_qH   in   LOGQH           qH value to load
//  q_ld_rdy  out  1               load accepted this cycle when q_ld && q_ld_rdy
//  in_vld    in   1               input beat valid (no backpressure)
//  in_C      in   LANES*(LOGQ+NSUB)  lane i at [i*(LOGQ+NSUB) +: LOGQ+NSUB]
//  in_tag    in   TAGW            sideband tag
//  out_vld   out  1               output beat valid
//  out_T     out  LANES*LOGQ      reduced results, lane i at [i*LOGQ +: LOGQ]
//  out_ovf   out  LANES           per lane: input was >= 2^NSUB*q (result not fully reduced)
//  out_tag   out  TAGW            tag of the output beat
// BEHAVIOUR
//  - LAT = FF_IN + popcount(FF_STG) + FF_OUT cycles, fixed; every in_vld beat appears on out_vld exactly LAT later.
//  - Stage k (internal width W = LOGQ+NSUB+1, zero-extended): D = X - (q<<k); X_next = D[W-1] ? X : D (borrow keeps X).
//  - Final: out_T = low LOGQ bits of stage-0 result; out_ovf = (stage-0 result >= q), computed per lane after stage 0.
//  - All lanes use the same q and step in lockstep; no inter-lane dependency.
//  - Modulus: q_reg (LOGQH) resets to 0. q_ld_rdy = (inflight == 0) && !in_vld. Load takes effect the next cycle;
//    q_ld with q_ld_rdy low is ignored (requester holds q_ld). in_vld and q_ld same cycle: beat accepted, load refused.
//  - inflight counter, width $clog2(LAT+1): +1 on accepted in_vld, -1 on out_vld, unchanged if both; 0 when LAT=0.
//  - Reset: all valid bits, inflight, q_reg, and registered out_T/out_ovf/out_tag clear to 0; out_vld=0 from the cycle
//    after rst asserts. Reset mid-operation drops in-flight beats (no output). Datapath regs other than outputs not reset.
//  - FF_OUT=0: outputs combinational from the last stage; their value during reset follows the (cleared) pipeline.
//  - q_reg = 0 (post-reset, never loaded): q = 1 when R>0, q = 0 when R=0; result defined by the stage equations.
//  - Data/tag registers only capture when the corresponding valid is 1 (clock-gating friendly); valid regs always update.
// STRUCTURE
//  - correction_ms_pkg: correction_ms_params_t {FF_IN, FF_STG, FF_OUT, NSUB}; function correction_ms_lat(params);
//    helper function building q from qH and R.
//  - Sub-module correction_ms_stage (one lane, one stage, SHIFT, FF parameters): conditional subtract of q<<SHIFT plus
//    optional register; top instantiates LANES x NSUB of them and owns valid/tag pipe, q_reg, inflight, load handshake.
// TESTING (LOGQ=16, LOGQH=8, NSUB=2, LANES=2, all FF=1, LAT=4; load qH=0xF0 -> q=0xF001, 2q=0x1E002)
//  1. in_C lanes {0x00000, 0x0F001} -> 4 cycles later out_T {0x0000, 0x0000}, out_ovf 00, out_vld for exactly 1 cycle.
//  2. {0x3C003 (4q-1), 0x1E003} -> out_T {0xF000, 0x0001}, out_ovf 00; tag 0xA in -> tag 0xA out.
//  3. {0x3C004 (4q), 0x0F000} -> out_T {0xF001, 0xF000}, out_ovf {1,0}.
//  4. Back-to-back beats every cycle for 10 cycles -> 10 contiguous out_vld, order/tags preserved, q_ld_rdy low throughout
//     and until 4 cycles after last beat; q_ld held meanwhile loads only then.
//  5. q_ld and in_vld same cycle -> beat processed with old q, load refused; reload qH=0x80 (q=0x8001) after drain,
//     in_C 0x10002 -> out_T 0x0000.
//  6. rst asserted with 3 beats in flight -> out_vld stays 0, inflight=0, q_ld_rdy=1 after release, q_reg=0.

Source files
------------

// File: rtl/correction_ms_pkg.sv
// Shared types and helpers for the correction_ms final-reduction block:
// pipeline latency bookkeeping and construction of q from its loadable high part.
package correction_ms_pkg;

  localparam int CORRECTION_MS_MAXW = 256;

  typedef struct packed {
    logic [31:0] ff_in;
    logic [31:0] ff_stg;
    logic [31:0] ff_out;
    logic [31:0] nsub;
  } correction_ms_params_t;

  // Latency counts the input/output registers plus one per registered stage.
  function automatic logic [31:0] correction_ms_lat(input correction_ms_params_t p);
    logic [31:0] n;
    n = p.ff_in + p.ff_out;
    for (int i = 0; i < 32; i++) begin
      if ((32'(i) < p.nsub) && p.ff_stg[i]) n = n + 32'd1;
    end
    return n;
  endfunction

  // q = {qH, zeros, 1} when there are low bits below qH, otherwise q is qH itself.
  function automatic logic [CORRECTION_MS_MAXW-1:0] correction_ms_build_q(
    input logic [CORRECTION_MS_MAXW-1:0] qh,
    input int                            r
  );
    logic [CORRECTION_MS_MAXW-1:0] q;
    if (r > 0) begin
      q    = qh << r;
      q[0] = 1'b1;
    end else begin
      q = qh;
    end
    return q;
  endfunction

endpackage

// File: rtl/correction_ms_stage.sv
// One lane, one stage: subtract q<<SHIFT unless that borrows, with an optional
// capture register that only loads on a valid beat.
module correction_ms_stage
  import correction_ms_pkg::*;
#(
  parameter int W     = 67,
  parameter int SHIFT = 0,
  parameter bit FF    = 1'b1
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] q,
  input  logic [W-1:0] x_in,
  output logic [W-1:0] x_out
);

  logic [W-1:0] q_sh;
  logic [W-1:0] diff;
  logic [W-1:0] x_nxt;

  assign q_sh  = q << SHIFT;
  assign diff  = x_in - q_sh;
  assign x_nxt = diff[W-1] ? x_in : diff;

  if (FF) begin : g_reg
    logic [W-1:0] x_r;
    always_ff @(posedge clk) begin
      if (en) x_r <= x_nxt;
    end
    assign x_out = x_r;
  end else begin : g_comb
    assign x_out = x_nxt;
  end

endmodule

// File: rtl/correction_ms.sv
// Multi-lane final correction: NSUB conditional subtractions of q<<k bring C into
// [0, q), with a valid/tag pipe, loadable modulus and per-lane overflow flag.
module correction_ms
  import correction_ms_pkg::*;
#(
  parameter int              LOGQ   = 64,
  parameter int              LOGQH  = 17,
  parameter int              NSUB   = 2,
  parameter int              LANES  = 1,
  parameter int              TAGW   = 4,
  parameter int              FF_IN  = 1,
  parameter logic [NSUB-1:0] FF_STG = '1,
  parameter int              FF_OUT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  q_ld,
  input  logic [LOGQH-1:0]      q_ld_qH,
  output logic                  q_ld_rdy,
  input  logic                  in_vld,
  input  logic [LANES*(LOGQ+NSUB)-1:0] in_C,
  input  logic [TAGW-1:0]       in_tag,
  output logic                  out_vld,
  output logic [LANES*LOGQ-1:0] out_T,
  output logic [LANES-1:0]      out_ovf,
  output logic [TAGW-1:0]       out_tag
);

  localparam int R  = LOGQ - LOGQH;
  localparam int CW = LOGQ + NSUB;
  localparam int W  = CW + 1;
  localparam correction_ms_params_t P = '{
    ff_in:  32'(FF_IN),
    ff_stg: 32'(FF_STG),
    ff_out: 32'(FF_OUT),
    nsub:   32'(NSUB)
  };
  localparam int LAT = int'(correction_ms_lat(P));
  localparam int IW  = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef logic [W-1:0] word_t;

  logic [LOGQH-1:0]              q_reg;
  logic [IW-1:0]                 inflight;
  logic [CORRECTION_MS_MAXW-1:0] qh_ext;
  word_t                         q_full;

  logic [NSUB:0]                 vld_p;
  logic [NSUB:0][TAGW-1:0]       tag_p;
  logic [LANES-1:0][NSUB:0][W-1:0] x_p;
  logic [LANES*CW-1:0]           c_s;

  assign qh_ext = {{(CORRECTION_MS_MAXW-LOGQH){1'b0}}, q_reg};
  assign q_full = word_t'(correction_ms_build_q(qh_ext, R));

  // Loads are only allowed with an empty pipe so no beat ever sees two moduli.
  assign q_ld_rdy = (inflight == '0) && !in_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      q_reg    <= '0;
    end else begin
      if (in_vld && !out_vld)      inflight <= inflight + 1'b1;
      else if (!in_vld && out_vld) inflight <= inflight - 1'b1;
      if (q_ld && q_ld_rdy)        q_reg <= q_ld_qH;
    end
  end

  if (FF_IN != 0) begin : g_in_reg
    logic                vld_r;
    logic [TAGW-1:0]     tag_r;
    logic [LANES*CW-1:0] c_r;
    always_ff @(posedge clk) begin
      if (rst) vld_r <= 1'b0;
      else     vld_r <= in_vld;
    end
    always_ff @(posedge clk) begin
      if (in_vld) begin
        tag_r <= in_tag;
        c_r   <= in_C;
      end
    end
    assign vld_p[NSUB] = vld_r;
    assign tag_p[NSUB] = tag_r;
    assign c_s         = c_r;
  end else begin : g_in_comb
    assign vld_p[NSUB] = in_vld;
    assign tag_p[NSUB] = in_tag;
    assign c_s         = in_C;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane_in
    assign x_p[l][NSUB] = {1'b0, c_s[l*CW +: CW]};
  end

  // Stages run from the largest shift down; index k holds the result after stage k.
  for (genvar k = 0; k < NSUB; k++) begin : g_stg
    if (FF_STG[k]) begin : g_reg
      logic            vld_r;
      logic [TAGW-1:0] tag_r;
      always_ff @(posedge clk) begin
        if (rst) vld_r <= 1'b0;
        else     vld_r <= vld_p[k+1];
      end
      always_ff @(posedge clk) begin
        if (vld_p[k+1]) tag_r <= tag_p[k+1];
      end
      assign vld_p[k] = vld_r;
      assign tag_p[k] = tag_r;
    end else begin : g_comb
      assign vld_p[k] = vld_p[k+1];
      assign tag_p[k] = tag_p[k+1];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
      correction_ms_stage #(
        .W     (W),
        .SHIFT (k),
        .FF    (FF_STG[k])
      ) u_stage (
        .clk   (clk),
        .en    (vld_p[k+1]),
        .q     (q_full),
        .x_in  (x_p[l][k+1]),
        .x_out (x_p[l][k])
      );
    end
  end

  logic [LANES*LOGQ-1:0] t_c;
  logic [LANES-1:0]      ovf_c;

  for (genvar l = 0; l < LANES; l++) begin : g_lane_out
    assign t_c[l*LOGQ +: LOGQ] = x_p[l][0][LOGQ-1:0];
    assign ovf_c[l]            = (x_p[l][0] >= q_full);
  end

  if (FF_OUT != 0) begin : g_out_reg
    logic                  vld_r;
    logic [LANES*LOGQ-1:0] t_r;
    logic [LANES-1:0]      ovf_r;
    logic [TAGW-1:0]       tag_r;
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_r <= 1'b0;
        t_r   <= '0;
        ovf_r <= '0;
        tag_r <= '0;
      end else begin
        vld_r <= vld_p[0];
        if (vld_p[0]) begin
          t_r   <= t_c;
          ovf_r <= ovf_c;
          tag_r <= tag_p[0];
        end
      end
    end
    assign out_vld = vld_r;
    assign out_T   = t_r;
    assign out_ovf = ovf_r;
    assign out_tag = tag_r;
  end else begin : g_out_comb
    assign out_vld = vld_p[0];
    assign out_T   = t_c;
    assign out_ovf = ovf_c;
    assign out_tag = tag_p[0];
  end

endmodule

// File: tb/tb_correction_ms.sv
// Self-checking bench for correction_ms (16-bit q, 2 lanes, fully registered, latency 4)
// against a delay-line model that reduces each lane with plain modular arithmetic.
module tb_correction_ms;

  localparam int LOGQ  = 16;
  localparam int LOGQH = 8;
  localparam int NSUB  = 2;
  localparam int LANES = 2;
  localparam int TAGW  = 4;
  localparam int LAT   = 4;
  localparam int CW    = LOGQ + NSUB;

  logic                     clk      = 1'b0;
  logic                     rst      = 1'b1;
  logic                     q_ld     = 1'b0;
  logic [LOGQH-1:0]         q_ld_qH  = '0;
  logic                     q_ld_rdy;
  logic                     in_vld   = 1'b0;
  logic [LANES*CW-1:0]      in_C     = '0;
  logic [TAGW-1:0]          in_tag   = '0;
  logic                     out_vld;
  logic [LANES*LOGQ-1:0]    out_T;
  logic [LANES-1:0]         out_ovf;
  logic [TAGW-1:0]          out_tag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          vld;
    logic [31:0] t;
    logic [1:0]  ovf;
    logic [3:0]  tag;
  } beat_t;

  beat_t      dl[$];
  logic [7:0] mqh = '0;

  correction_ms #(
    .LOGQ   (LOGQ),
    .LOGQH  (LOGQH),
    .NSUB   (NSUB),
    .LANES  (LANES),
    .TAGW   (TAGW),
    .FF_IN  (1),
    .FF_STG (2'b11),
    .FF_OUT (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .q_ld     (q_ld),
    .q_ld_qH  (q_ld_qH),
    .q_ld_rdy (q_ld_rdy),
    .in_vld   (in_vld),
    .in_C     (in_C),
    .in_tag   (in_tag),
    .out_vld  (out_vld),
    .out_T    (out_T),
    .out_ovf  (out_ovf),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  function automatic beat_t idle_beat();
    beat_t b;
    b = '{vld: 1'b0, t: '0, ovf: '0, tag: '0};
    return b;
  endfunction

  // Anything at or above 4q cannot be fully reduced: it leaves C-3q and flags overflow.
  function automatic beat_t model_beat(input int unsigned c0, input int unsigned c1,
                                       input logic [3:0] tag, input logic [7:0] qh);
    beat_t       b;
    int unsigned q;
    int unsigned c[2];
    q     = ({24'd0, qh} << 8) | 32'd1;
    c[0]  = c0;
    c[1]  = c1;
    b.vld = 1'b1;
    b.tag = tag;
    b.t   = '0;
    b.ovf = '0;
    for (int l = 0; l < 2; l++) begin
      if (c[l] >= 4 * q) begin
        b.ovf[l]         = 1'b1;
        b.t[l*16 +: 16]  = 16'(c[l] - 3 * q);
      end else begin
        b.t[l*16 +: 16]  = 16'(c[l] % q);
      end
    end
    return b;
  endfunction

  function automatic int unsigned rand_c(input logic [7:0] qh);
    int unsigned q;
    int unsigned v;
    q = ({24'd0, qh} << 8) | 32'd1;
    case ($urandom_range(0, 3))
      0:       v = $urandom_range(0, 32'h3FFFF);
      1:       v = $urandom_range(0, 4 * q - 1);
      2:       v = 4 * q - 2 + $urandom_range(0, 3);
      default: v = $urandom_range(0, 3) * q + $urandom_range(0, 1);
    endcase
    return v & 32'h3FFFF;
  endfunction

  // Advance one cycle: hand back what should be on the outputs now, drive new inputs,
  // and record the beat that should emerge LAT cycles later.
  task automatic drive_cycle(input bit r, input bit v, input int unsigned c0, input int unsigned c1,
                             input logic [3:0] tag, input bit ld, input logic [7:0] qh,
                             output beat_t e, output bit exp_rdy);
    beat_t nb;
    @(negedge clk);
    e       = dl[0];
    rst     = r;
    in_vld  = v;
    in_C    = {CW'(c1), CW'(c0)};
    in_tag  = tag;
    q_ld    = ld;
    q_ld_qH = qh;
    #1;
    exp_rdy = !v;
    foreach (dl[i]) if (dl[i].vld) exp_rdy = 1'b0;
    if (r) begin
      mqh = '0;
      dl.delete();
      repeat (LAT) dl.push_back(idle_beat());
    end else begin
      nb = v ? model_beat(c0, c1, tag, mqh) : idle_beat();
      if (ld && exp_rdy) mqh = qh;
      void'(dl.pop_front());
      dl.push_back(nb);
    end
  endtask

  task automatic test_reset();
    beat_t e;
    bit    r;
    repeat (3) drive_cycle(1'b1, 1'b0, 0, 0, 4'h0, 1'b0, 8'h00, e, r);
    total++;
    if ({out_vld, out_T, out_ovf, out_tag} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %h required 0", {out_vld, out_T, out_ovf, out_tag});
    end
    drive_cycle(1'b0, 1'b0, 0, 0, 4'h0, 1'b0, 8'h00, e, r);
    total++;
    if (q_ld_rdy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_rdy: got %b required 1", q_ld_rdy);
    end
    total++;
    if (out_vld !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_vld: got %b required 0", out_vld);
    end
  endtask

  task automatic test_directed();
    beat_t       e;
    bit          r;
    int unsigned vc0[3] = '{32'h00000, 32'h3C003, 32'h3C004};
    int unsigned vc1[3] = '{32'h0F001, 32'h1E003, 32'h0F000};
    logic [31:0] vt[3]  = '{32'h0000_0000, 32'h0001_F000, 32'hF000_F001};
    logic [1:0]  vo[3]  = '{2'b00, 2'b00, 2'b01};
    logic [3:0]  vg[3]  = '{4'h3, 4'hA, 4'h5};
    drive_cycle(1'b0, 1'b0, 0, 0, 4'h0, 1'b1, 8'hF0, e, r);
    total++;
    if (q_ld_rdy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL directed_load_rdy: got %b required 1", q_ld_rdy);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, vc0[i], vc1[i], vg[i], 1'b0, 8'h00, e, r);
      for (int k = 1; k <= 5; k++) begin
        drive_cycle(1'b0, 1'b0, 0, 0, 4'h0, 1'b0, 8'h00, e, r);
        total++;
        if (out_vld !== (k == 4)) begin
          bad++;
          $display("[TB] FAIL directed%0d_vld_k%0d: got %b required %b", i, k, out_vld, (k == 4));
        end
        if (k == 4) begin
          total++;
          if ({out_tag, out_ovf, out_T} !== {vg[i], vo[i], vt[i]}) begin
            bad++;
            $display("[TB] FAIL directed%0d_data: got tag/ovf/T %h/%b/%h required %h/%b/%h",
                     i, out_tag, out_ovf, out_T, vg[i], vo[i], vt[i]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    beat_t e;
    bit    r;
    bit    hold      = 1'b1;
    int    first_rdy = -1;
    int    n_out     = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 10)
        drive_cycle(1'b0, 1'b1, rand_c(mqh), rand_c(mqh), 4'(i), 1'b1, 8'h3C, e, r);
      else
        drive_cycle(1'b0, 1'b0, 0, 0, 4'h0, hold, 8'h3C, e, r);
      total++;
      if (out_vld !== e.vld) begin
        bad++;
        $display("[TB] FAIL b2b_vld[%0d]: got %b required %b", i, out_vld, e.vld);
      end
      if (e.vld) begin
        total++;
        if ({out_tag, out_ovf, out_T} !== {e.tag, e.ovf, e.t}) begin
          bad++;
          $display("[TB] FAIL b2b_data[%0d]: got %h required %h", i, {out_tag, out_ovf, out_T}, {e.tag, e.ovf, e.t});
        end
      end
      total++;
      if (q_ld_rdy !== r) begin
        bad++;
        $display("[TB] FAIL b2b_rdy[%0d]: got %b required %b", i, q_ld_rdy, r);
      end
      if (out_vld === 1'b1) n_out++;
      if (i >= 10 && hold && q_ld_rdy === 1'b1) begin
        first_rdy = i - 9;
        hold      = 1'b0;
      end
    end
    total++;
    if (first_rdy !== 5) begin
      bad++;
      $display("[TB] FAIL b2b_load_delay: got %0d required 5", first_rdy);
    end
    total++;
    if (n_out !== 10) begin
      bad++;
      $display("[TB] FAIL b2b_out_count: got %0d required 10", n_out);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive_cycle(1'b0, 1'b1, rand_c(mqh), rand_c(mqh), 4'hE, 1'b0, 8'h00, e, r);
      else        drive_cycle(1'b0, 1'b0, 0, 0, 4'h0, 1'b0, 8'h00, e, r);
      total++;
      if (out_vld !== e.vld || (e.vld && {out_tag, out_ovf, out_T} !== {e.tag, e.ovf, e.t})) begin
        bad++;
        $display("[TB] FAIL b2b_newq[%0d]: got %b/%h required %b/%h", i, out_vld,
                 {out_tag, out_ovf, out_T}, e.vld, {e.tag, e.ovf, e.t});
      end
    end
  endtask

  task automatic test_collision();
    beat_t e;
    bit    r;
    drive_cycle(1'b0, 1'b1, 32'h0A123, 32'h2F00F, 4'h6, 1'b1, 8'h80, e, r);
    total++;
    if (q_ld_rdy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL collide_rdy: got %b required 0", q_ld_rdy);
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 5)      drive_cycle(1'b0, 1'b0, 0, 0, 4'h0, 1'b1, 8'h80, e, r);
      else if (i == 6) drive_cycle(1'b0, 1'b1, 32'h10002, 32'h10002, 4'h9, 1'b0, 8'h00, e, r);
      else             drive_cycle(1'b0, 1'b0, 0, 0, 4'h0, 1'b0, 8'h00, e, r);
      total++;
      if (out_vld !== e.vld || (e.vld && {out_tag, out_ovf, out_T} !== {e.tag, e.ovf, e.t})) begin
        bad++;
        $display("[TB] FAIL collide_out[%0d]: got %b/%h required %b/%h", i, out_vld,
                 {out_tag, out_ovf, out_T}, e.vld, {e.tag, e.ovf, e.t});
      end
      total++;
      if (q_ld_rdy !== r) begin
        bad++;
        $display("[TB] FAIL collide_rdy[%0d]: got %b required %b", i, q_ld_rdy, r);
      end
      if (i == 10) begin
        total++;
        if ({out_vld, out_tag, out_ovf, out_T} !== {1'b1, 4'h9, 2'b00, 32'h0}) begin
          bad++;
          $display("[TB] FAIL collide_reload_result: got %b/%h/%b/%h required 1/9/00/00000000",
                   out_vld, out_tag, out_ovf, out_T);
        end
      end
    end
  endtask

  task automatic test_random();
    beat_t e;
    bit    r;
    bit    v;
    bit    ld;
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom_range(0, 9) < 7);
      ld = ($urandom_range(0, 5) == 0);
      drive_cycle(1'b0, v, rand_c(mqh), rand_c(mqh), 4'($urandom_range(0, 15)), ld,
                  8'($urandom_range(0, 255)), e, r);
      total++;
      if (out_vld !== e.vld) begin
        bad++;
        $display("[TB] FAIL rand_vld[%0d]: got %b required %b", i, out_vld, e.vld);
      end
      if (e.vld) begin
        total++;
        if ({out_tag, out_ovf, out_T} !== {e.tag, e.ovf, e.t}) begin
          bad++;
          $display("[TB] FAIL rand_data[%0d]: got %h required %h", i, {out_tag, out_ovf, out_T}, {e.tag, e.ovf, e.t});
        end
      end
      total++;
      if (q_ld_rdy !== r) begin
        bad++;
        $display("[TB] FAIL rand_rdy[%0d]: got %b required %b", i, q_ld_rdy, r);
      end
    end
    repeat (LAT + 1) drive_cycle(1'b0, 1'b0, 0, 0, 4'h0, 1'b0, 8'h00, e, r);
  endtask

  task automatic test_reset_midflight();
    beat_t e;
    bit    r;
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b0, 1'b1, rand_c(mqh), rand_c(mqh), 4'(i + 1), 1'b0, 8'h00, e, r);
    for (int i = 0; i < 9; i++) begin
      drive_cycle(i < 2, 1'b0, 0, 0, 4'h0, 1'b0, 8'h00, e, r);
      if (i > 0) begin
        total++;
        if (out_vld !== 1'b0) begin
          bad++;
          $display("[TB] FAIL midrst_vld[%0d]: got %b required 0", i, out_vld);
        end
      end
      if (i >= 2) begin
        total++;
        if (q_ld_rdy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL midrst_rdy[%0d]: got %b required 1", i, q_ld_rdy);
        end
      end
    end
    // After reset q_reg is 0, so q = 1: an input of 5 leaves 2 and flags overflow.
    for (int k = 0; k <= 5; k++) begin
      if (k == 0) drive_cycle(1'b0, 1'b1, 5, 5, 4'hC, 1'b0, 8'h00, e, r);
      else        drive_cycle(1'b0, 1'b0, 0, 0, 4'h0, 1'b0, 8'h00, e, r);
      if (k == 4) begin
        total++;
        if ({out_vld, out_tag, out_ovf, out_T} !== {1'b1, 4'hC, 2'b11, 32'h0002_0002}) begin
          bad++;
          $display("[TB] FAIL midrst_q_zero: got %b/%h/%b/%h required 1/c/11/00020002",
                   out_vld, out_tag, out_ovf, out_T);
        end
      end
    end
  endtask

  initial begin
    repeat (LAT) dl.push_back(idle_beat());
    test_reset();
    test_directed();
    test_back_to_back();
    test_collision();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
